// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Program counter and fetch stage. Drives a byte address to a registered-read
// instruction memory (1-cycle latency) and captures the returned word into an
// IF/ID register for the decoder. Handles sequential advance (+2), decoder
// stall, branch redirect with wrong-path squash, and HALT detection.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   Adds instr_count, a saturating count of instructions consumed by decode.
//
// Ports:
//   clk            in   system clock, rising edge
//   reset_n        in   asynchronous active-low reset
//   imem_addr      out  byte address to instruction memory (combinational)
//   imem_data      in   word returned by memory for last cycle's address
//   stall          in   decode cannot accept; hold output register
//   branch_taken   in   redirect fetch this cycle
//   branch_target  in   redirect byte address (bit 0 forced to 0)
//   instr          out  captured instruction
//   instr_pc       out  byte address of instr
//   instr_valid    out  instr/instr_pc hold a valid, non-squashed instruction
//   halted         out  HALT word captured; fetch frozen until reset
//   instr_count    out  (FETCH_PERF_CNT_EN only) consumed-instruction count
module instruction_fetch_unit #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 16,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       instr_count
`endif
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              req_valid;

  // Branch redirect wins. On stall (or once halted) the memory re-reads the
  // address it sampled last edge so the in-flight word is presented again.
  always_comb begin
    imem_addr = fetch_pc;
    if (state == RUN && branch_taken)
      imem_addr = branch_target & ~ADDR_W'(1);
    else if (stall || state == HALTED)
      imem_addr = req_pc;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      req_pc      <= RESET_PC;
      req_valid   <= 1'b0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
    end else if (state == RUN) begin
      req_pc    <= imem_addr;
      req_valid <= 1'b1;
      fetch_pc  <= imem_addr + ADDR_W'(2);
      if (branch_taken) begin
        // Word arriving this edge is wrong-path; drop it, even if it is HALT.
        instr_valid <= 1'b0;
      end else if (!stall) begin
        if (req_valid) begin
          instr       <= imem_data;
          instr_pc    <= req_pc;
          instr_valid <= 1'b1;
          if (imem_data == HALT_WORD) begin
            halted <= 1'b1;
            state  <= HALTED;
          end
        end else begin
          instr_valid <= 1'b0;
        end
      end
    end else begin
      // Halted: fetch frozen, branches ignored; the HALT word remains
      // presented to decode until decode accepts it.
      req_valid <= 1'b0;
      if (!stall)
        instr_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      instr_count <= '0;
    else if (instr_valid && !stall && instr_count != 16'hFFFF)
      instr_count <= instr_count + 16'd1;
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset_n;
  logic [7:0]  imem_addr;
  logic [15:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [7:0]  branch_target;
  logic [15:0] instr;
  logic [7:0]  instr_pc;
  logic        instr_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] instr_count;
`endif

  instruction_fetch_unit dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .halted       (halted)
`ifdef FETCH_PERF_CNT_EN
    ,
    .instr_count  (instr_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-organised instruction memory, registered read.
  logic [15:0] mem [0:127];
  always @(posedge clk) imem_data <= mem[imem_addr[7:1]];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        st;
    logic        br;
    logic [7:0]  tgt;
    logic [7:0]  addr;
    logic        valid;
    logic [7:0]  pc;
    logic [15:0] ins;
    logic        hlt;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(logic st, logic br, logic [7:0] tgt, logic [7:0] addr,
                              logic valid, logic [7:0] pc, logic [15:0] ins, logic hlt);
    vec_t v;
    v.st = st; v.br = br; v.tgt = tgt; v.addr = addr;
    v.valid = valid; v.pc = pc; v.ins = ins; v.hlt = hlt;
    tbl.push_back(v);
  endfunction

  task automatic do_reset();
    @(negedge clk);
    stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;
    reset_n = 1'b0;
    #1;
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_instr", 32'(instr), 32'd0);
    check("rst_pc", 32'(instr_pc), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Drive inputs mid-cycle, check the combinational address, clock once,
  // then check the registered outputs just after the edge.
  task automatic step(input int idx, input vec_t v);
    stall = v.st; branch_taken = v.br; branch_target = v.tgt;
    #1;
    check($sformatf("addr[%0d]", idx), 32'(imem_addr), 32'(v.addr));
    @(posedge clk);
    #1;
    check($sformatf("valid[%0d]", idx), 32'(instr_valid), 32'(v.valid));
    check($sformatf("pc[%0d]", idx), 32'(instr_pc), 32'(v.pc));
    check($sformatf("halted[%0d]", idx), 32'(halted), 32'(v.hlt));
    if (v.valid)
      check($sformatf("instr[%0d]", idx), 32'(instr), 32'(v.ins));
    stall = 1'b0; branch_taken = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0]  = 16'hFE21;
    mem[1]  = 16'hFB22;
    mem[2]  = 16'h2358;
    mem[31] = 16'h0000;   // HALT at 0x3E

    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 8'h00;

    //   st br tgt    addr   v  pc     instr      h
    // Sequential start-up
    add(0, 0, 8'h00, 8'h00, 0, 8'h00, 16'h0000, 0);
    add(0, 0, 8'h00, 8'h02, 1, 8'h00, 16'hFE21, 0);
    add(0, 0, 8'h00, 8'h04, 1, 8'h02, 16'hFB22, 0);
    // 3-cycle stall holding 0x02, memory re-reads 0x04
    add(1, 0, 8'h00, 8'h04, 1, 8'h02, 16'hFB22, 0);
    add(1, 0, 8'h00, 8'h04, 1, 8'h02, 16'hFB22, 0);
    add(1, 0, 8'h00, 8'h04, 1, 8'h02, 16'hFB22, 0);
    add(0, 0, 8'h00, 8'h06, 1, 8'h04, 16'h2358, 0);
    add(0, 0, 8'h00, 8'h08, 1, 8'h06, 16'hA003, 0);
    add(0, 0, 8'h00, 8'h0A, 1, 8'h08, 16'hA004, 0);
    // Branch to 0x31 (odd target forced even)
    add(0, 1, 8'h31, 8'h30, 0, 8'h08, 16'h0000, 0);
    add(0, 0, 8'h00, 8'h32, 1, 8'h30, 16'hA018, 0);
    // Back to 0x06, then branch with stall on the same cycle
    add(0, 1, 8'h07, 8'h06, 0, 8'h30, 16'h0000, 0);
    add(0, 0, 8'h00, 8'h08, 1, 8'h06, 16'hA003, 0);
    add(0, 0, 8'h00, 8'h0A, 1, 8'h08, 16'hA004, 0);
    add(1, 1, 8'h31, 8'h30, 0, 8'h08, 16'h0000, 0);
    add(0, 0, 8'h00, 8'h32, 1, 8'h30, 16'hA018, 0);
    // Wrap: 0xFC, 0xFE, 0x00
    add(0, 1, 8'hFC, 8'hFC, 0, 8'h30, 16'h0000, 0);
    add(0, 0, 8'h00, 8'hFE, 1, 8'hFC, 16'hA07E, 0);
    add(0, 0, 8'h00, 8'h00, 1, 8'hFE, 16'hA07F, 0);
    add(0, 0, 8'h00, 8'h02, 1, 8'h00, 16'hFE21, 0);
    // Run into HALT at 0x3E
    add(0, 1, 8'h38, 8'h38, 0, 8'h00, 16'h0000, 0);
    add(0, 0, 8'h00, 8'h3A, 1, 8'h38, 16'hA01C, 0);
    add(0, 0, 8'h00, 8'h3C, 1, 8'h3A, 16'hA01D, 0);
    add(0, 0, 8'h00, 8'h3E, 1, 8'h3C, 16'hA01E, 0);
    add(0, 0, 8'h00, 8'h40, 1, 8'h3E, 16'h0000, 1);
    // Halted: stall keeps HALT word valid; branches ignored, address frozen
    add(1, 1, 8'h00, 8'h40, 1, 8'h3E, 16'h0000, 1);
    add(0, 1, 8'h00, 8'h40, 0, 8'h3E, 16'h0000, 1);
    add(0, 0, 8'h00, 8'h40, 0, 8'h3E, 16'h0000, 1);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) step(i, tbl[i]);

    // Reset pulse restores fetch from 0x00
    do_reset();
    step(100, '{0, 0, 8'h00, 8'h00, 0, 8'h00, 16'h0000, 0});
    step(101, '{0, 0, 8'h00, 8'h02, 1, 8'h00, 16'hFE21, 0});

    // Branch on the same edge the HALT word would be captured: branch wins
    step(102, '{0, 1, 8'h3C, 8'h3C, 0, 8'h00, 16'h0000, 0});
    step(103, '{0, 0, 8'h00, 8'h3E, 1, 8'h3C, 16'hA01E, 0});
    step(104, '{0, 1, 8'h00, 8'h00, 0, 8'h3C, 16'h0000, 0});
    step(105, '{0, 0, 8'h00, 8'h02, 1, 8'h00, 16'hFE21, 0});
    step(106, '{0, 0, 8'h00, 8'h04, 1, 8'h02, 16'hFB22, 0});

`ifdef FETCH_PERF_CNT_EN
    do_reset();
    check("cnt_rst", 32'(instr_count), 32'd0);
    // 9 edges, stalls on edges 4 and 6: consumption on edges 3,5,7,8,9
    for (int e = 1; e <= 9; e++) begin
      stall = (e == 4 || e == 6);
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    check("cnt_five", 32'(instr_count), 32'd5);
    #3;
    reset_n = 1'b0;
    #1;
    check("cnt_async_rst", 32'(instr_count), 32'd0);
    check("async_rst_valid", 32'(instr_valid), 32'd0);
    check("async_rst_instr", 32'(instr), 32'd0);
    check("async_rst_pc", 32'(instr_pc), 32'd0);
    reset_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
